// File: rtl/truth_table_extractor_if.sv
// Bus between the truth-table extractor and its harness.
// Optional TTX_ONES_COUNT_EN adds the ones_count result field.
interface truth_table_extractor_if #(
   parameter int unsigned N_INPUTS = 3
);
   localparam int unsigned M = 1 << N_INPUTS;

   logic                start;
   logic                abort;
   logic [N_INPUTS-1:0] dut_in;
   logic                dut_out;
   logic                busy;
   logic                done;
   logic [M-1:0]        tt_out;
`ifdef TTX_ONES_COUNT_EN
   logic [N_INPUTS:0]   ones_count;
`endif

`ifdef TTX_ONES_COUNT_EN
   modport master (output start, abort, dut_out,
                   input  dut_in, busy, done, tt_out, ones_count);
   modport slave  (input  start, abort, dut_out,
                   output dut_in, busy, done, tt_out, ones_count);
`else
   modport master (output start, abort, dut_out,
                   input  dut_in, busy, done, tt_out);
   modport slave  (input  start, abort, dut_out,
                   output dut_in, busy, done, tt_out);
`endif
endinterface

// File: rtl/truth_table_extractor.sv
// Truth-table extractor: walks every input combination of an N-input
// netlist, waits a settle window, samples its output and publishes the
// assembled 2^N-bit truth table. Optional macro TTX_ONES_COUNT_EN adds a
// popcount of the published table.
module truth_table_extractor #(
   parameter int unsigned N_INPUTS      = 3,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   truth_table_extractor_if.slave bus
);
   localparam int unsigned M     = 1 << N_INPUTS;
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [N_INPUTS-1:0] LAST_IDX   = N_INPUTS'(M - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [N_INPUTS-1:0] idx_q, idx_d;
   logic [N_INPUTS-1:0] din_q, din_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [M-1:0]        shadow_q, shadow_d;
   logic [M-1:0]        tt_q, tt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef TTX_ONES_COUNT_EN
   logic [N_INPUTS:0]   ones_q, ones_d;

   function automatic logic [N_INPUTS:0] popcount(input logic [M-1:0] v);
      logic [N_INPUTS:0] sum;
      sum = '0;
      for (int unsigned i = 0; i < M; i++) begin
         sum = sum + (N_INPUTS+1)'(v[i]);
      end
      return sum;
   endfunction
`endif

   // Next-state and next-output logic for the sweep
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      din_d    = din_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tt_d     = tt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef TTX_ONES_COUNT_EN
      ones_d   = ones_q;
`endif
      if ((state_q != IDLE) && bus.abort) begin
         // abort beats a concurrent final sample; partial table is dropped
         state_d = IDLE;
         busy_d  = 1'b0;
         din_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  busy_d  = 1'b1;
                  idx_d   = '0;
                  din_d   = '0;
                  cnt_d   = CNT_RELOAD;
                  state_d = SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_d = SAMPLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            SAMPLE: begin
               if (idx_q == LAST_IDX) begin
                  tt_d        = shadow_q;
                  tt_d[M-1]   = bus.dut_out;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = IDLE;
`ifdef TTX_ONES_COUNT_EN
                  ones_d      = popcount(tt_d);
`endif
               end else begin
                  shadow_d[idx_q] = bus.dut_out;
                  idx_d           = idx_q + 1'b1;
                  din_d           = idx_q + 1'b1;
                  cnt_d           = CNT_RELOAD;
                  state_d         = SETTLE;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               din_d   = '0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         din_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         tt_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TTX_ONES_COUNT_EN
         ones_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         din_q    <= din_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef TTX_ONES_COUNT_EN
         ones_q   <= ones_d;
`endif
      end
   end

   assign bus.dut_in = din_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.tt_out = tt_q;
`ifdef TTX_ONES_COUNT_EN
   assign bus.ones_count = ones_q;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: two instances (N=3,S=2 and N=2,S=1)
// each driving a table-defined netlist model.
module tb_truth_table_extractor;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] fn_a;
   logic [3:0] fn_b;

   truth_table_extractor_if #(.N_INPUTS(3)) ifa ();
   truth_table_extractor_if #(.N_INPUTS(2)) ifb ();

   truth_table_extractor #(.N_INPUTS(3), .SETTLE_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   truth_table_extractor #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   // netlist model: output is the function table looked up by the input vector
   assign ifa.dut_out = fn_a[ifa.dut_in];
   assign ifb.dut_out = fn_b[ifb.dut_in];

   always #5 clk = ~clk;

   // pulse start on A for one edge; returns at the negedge after E0
   task automatic start_a();
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   // cycles from E0 to the done cycle (0 on timeout)
   task automatic wait_done_a(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (ifa.done === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ifa.busy, ifa.done, ifa.dut_in, ifa.tt_out} !== 13'h0) begin
         errors++;
         $display("FAIL reset_a: got busy=%b done=%b din=%0h tt=%0h required all 0",
                  ifa.busy, ifa.done, ifa.dut_in, ifa.tt_out);
      end
      checks++;
      if ({ifb.busy, ifb.done, ifb.dut_in, ifb.tt_out} !== 8'h0) begin
         errors++;
         $display("FAIL reset_b: got busy=%b done=%b din=%0h tt=%0h required all 0",
                  ifb.busy, ifb.done, ifb.dut_in, ifb.tt_out);
      end
`ifdef TTX_ONES_COUNT_EN
      checks++;
      if (ifa.ones_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_ones: got %0d required 0", ifa.ones_count);
      end
`endif
      rst_n = 1'b1;
   endtask

   // full cycle-by-cycle sweep of the 0x84 function
   task automatic test_basic();
      logic [7:0] prev;
      prev = ifa.tt_out;
      fn_a = 8'h84;
      start_a();
      checks++;
      if (ifa.busy !== 1'b1 || ifa.dut_in !== 3'd0) begin
         errors++;
         $display("FAIL basic_first: got busy=%b din=%0d required busy=1 din=0", ifa.busy, ifa.dut_in);
      end
      for (int j = 1; j <= 25; j++) begin
         @(negedge clk);
         if (j < 24) begin
            checks++;
            if (ifa.dut_in !== 3'(j / 3) || ifa.busy !== 1'b1 || ifa.done !== 1'b0 || ifa.tt_out !== prev) begin
               errors++;
               $display("FAIL basic_step%0d: got din=%0d busy=%b done=%b tt=%0h required din=%0d busy=1 done=0 tt=%0h",
                        j, ifa.dut_in, ifa.busy, ifa.done, ifa.tt_out, j / 3, prev);
            end
         end else if (j == 24) begin
            checks++;
            if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.tt_out !== 8'h84) begin
               errors++;
               $display("FAIL basic_done: got done=%b busy=%b tt=%0h required done=1 busy=0 tt=84",
                        ifa.done, ifa.busy, ifa.tt_out);
            end
`ifdef TTX_ONES_COUNT_EN
            checks++;
            if (ifa.ones_count !== 4'd2) begin
               errors++;
               $display("FAIL basic_ones: got %0d required 2", ifa.ones_count);
            end
`endif
         end else begin
            checks++;
            if (ifa.done !== 1'b0 || ifa.tt_out !== 8'h84) begin
               errors++;
               $display("FAIL basic_pulse: got done=%b tt=%0h required done=0 tt=84", ifa.done, ifa.tt_out);
            end
         end
      end
   endtask

   task automatic test_const();
      int n;
      for (int k = 0; k < 2; k++) begin
         fn_a = (k == 0) ? 8'h00 : 8'hFF;
         start_a();
         wait_done_a(n);
         checks++;
         if (n != 24 || ifa.tt_out !== fn_a) begin
            errors++;
            $display("FAIL const%0d: got latency=%0d tt=%0h required latency=24 tt=%0h", k, n, ifa.tt_out, fn_a);
         end
`ifdef TTX_ONES_COUNT_EN
         checks++;
         if (ifa.ones_count !== 4'($countones(fn_a))) begin
            errors++;
            $display("FAIL const_ones%0d: got %0d required %0d", k, ifa.ones_count, $countones(fn_a));
         end
`endif
         @(negedge clk);
         checks++;
         if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL const_idle%0d: got busy=%b required 0", k, ifa.busy);
         end
      end
   endtask

   task automatic test_abort();
      int dones;
      bit hit;
      fn_a = 8'h84;
      start_a();
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ifa.dut_in === 3'd5) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL abort_reach: got no dut_in=5 required dut_in=5 within 100 cycles");
      end
      ifa.abort = 1'b1;
      @(negedge clk);
      ifa.abort = 1'b0;
      checks++;
      if (ifa.busy !== 1'b0 || ifa.dut_in !== 3'd0 || ifa.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: got busy=%b din=%0d done=%b required 0 0 0", ifa.busy, ifa.dut_in, ifa.done);
      end
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifa.done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || ifa.tt_out !== 8'hFF || ifa.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold: got dones=%0d tt=%0h busy=%b required 0 ff 0", dones, ifa.tt_out, ifa.busy);
      end
`ifdef TTX_ONES_COUNT_EN
      checks++;
      if (ifa.ones_count !== 4'd8) begin
         errors++;
         $display("FAIL abort_ones: got %0d required 8", ifa.ones_count);
      end
`endif
   endtask

   // start with abort in IDLE still starts
   task automatic test_start_abort_idle();
      int n;
      fn_a = 8'h3C;
      @(negedge clk);
      ifa.start = 1'b1;
      ifa.abort = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      checks++;
      if (ifa.busy !== 1'b1) begin
         errors++;
         $display("FAIL idle_abort: got busy=%b required 1", ifa.busy);
      end
      wait_done_a(n);
      checks++;
      if (n != 24 || ifa.tt_out !== 8'h3C) begin
         errors++;
         $display("FAIL idle_abort_tt: got latency=%0d tt=%0h required 24 3c", n, ifa.tt_out);
      end
   endtask

   task automatic test_ignore_start();
      int n;
      fn_a = 8'h84;
      start_a();
      n = 0;
      for (int j = 1; j <= 200; j++) begin
         ifa.start = (j == 3 || j == 10);
         @(negedge clk);
         if (ifa.done === 1'b1) begin
            n = j;
            break;
         end
      end
      ifa.start = 1'b0;
      checks++;
      if (n != 24 || ifa.tt_out !== 8'h84) begin
         errors++;
         $display("FAIL ignore_start: got latency=%0d tt=%0h required 24 84", n, ifa.tt_out);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit hit;
      fn_a = 8'h5A;
      start_a();
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ifa.dut_in === 3'd4) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (!hit || {ifa.busy, ifa.done, ifa.dut_in, ifa.tt_out} !== 13'h0) begin
         errors++;
         $display("FAIL reset_mid: got hit=%b busy=%b done=%b din=%0d tt=%0h required hit=1 all 0",
                  hit, ifa.busy, ifa.done, ifa.dut_in, ifa.tt_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fn_a = 8'h80;
      start_a();
      wait_done_a(n);
      checks++;
      if (n != 24 || ifa.tt_out !== 8'h80) begin
         errors++;
         $display("FAIL reset_fresh: got latency=%0d tt=%0h required 24 80", n, ifa.tt_out);
      end
   endtask

   task automatic test_random();
      int n;
      for (int k = 0; k < 5; k++) begin
         fn_a = 8'($urandom);
         start_a();
         wait_done_a(n);
         checks++;
         if (n != 24 || ifa.tt_out !== fn_a) begin
            errors++;
            $display("FAIL random%0d: got latency=%0d tt=%0h required 24 %0h", k, n, ifa.tt_out, fn_a);
         end
`ifdef TTX_ONES_COUNT_EN
         checks++;
         if (ifa.ones_count !== 4'($countones(fn_a))) begin
            errors++;
            $display("FAIL random_ones%0d: got %0d required %0d", k, ifa.ones_count, $countones(fn_a));
         end
`endif
      end
   endtask

   // N=2,S=1 XOR with start held: each run is 8 cycles plus one IDLE cycle
   task automatic test_back_to_back();
      bit exp_done;
      fn_b = 4'h6;
      @(negedge clk);
      ifb.start = 1'b1;
      for (int j = 0; j < 36; j++) begin
         @(negedge clk);
         if (j == 19) ifb.start = 1'b0;
         exp_done = (j == 8 || j == 17 || j == 26);
         checks++;
         if (ifb.done !== exp_done) begin
            errors++;
            $display("FAIL b2b_done%0d: got %b required %b", j, ifb.done, exp_done);
         end
         if (exp_done) begin
            checks++;
            if (ifb.tt_out !== 4'h6) begin
               errors++;
               $display("FAIL b2b_tt%0d: got %0h required 6", j, ifb.tt_out);
            end
`ifdef TTX_ONES_COUNT_EN
            checks++;
            if (ifb.ones_count !== 3'd2) begin
               errors++;
               $display("FAIL b2b_ones%0d: got %0d required 2", j, ifb.ones_count);
            end
`endif
         end
      end
      ifb.start = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      ifb.start = 1'b0;
      ifb.abort = 1'b0;
      fn_a      = 8'h00;
      fn_b      = 4'h0;
      test_reset();
      test_basic();
      test_const();
      test_abort();
      test_start_abort_idle();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
